// File: rtl/serial_add_sub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: state encoding and
// the counter-width helper.
package serial_add_sub_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    typedef enum logic [1:0] {
        StIdle  = S_IDLE,
        StShift = S_SHIFT,
        StDone  = S_DONE
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/full_add.sv
// Existing 1-bit full-adder cell: sum and carry-out of a, b and carry-in.
module full_add (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic y,
    output logic carry
);

    assign y     = a ^ b ^ cin;
    assign carry = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial WIDTH-bit adder/subtractor: streams operand bits LSB first through
// one full_add cell with a registered carry, then reports result/cout/ovf.
module serial_add_sub
    import serial_add_sub_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             sub_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             cout_o,
    output logic             ovf_o
);

    localparam int unsigned      CntW    = cnt_width(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  op_a_q, op_a_d;
    logic [WIDTH-1:0]  op_b_q, op_b_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic              cy_q, cy_d;
    logic              c_msb_q, c_msb_d;
    logic              done_q, done_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;
    logic              fa_y, fa_carry;

    full_add u_full_add (
        .a     (op_a_q[0]),
        .b     (op_b_q[0]),
        .cin   (cy_q),
        .y     (fa_y),
        .carry (fa_carry)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        res_d   = res_q;
        cy_d    = cy_q;
        c_msb_d = c_msb_q;
        done_d  = 1'b0;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    // Subtraction is a + ~b + 1: invert b and seed the carry with 1.
                    op_a_d  = a_i;
                    op_b_d  = sub_i ? ~b_i : b_i;
                    cy_d    = sub_i;
                    cnt_d   = '0;
                    res_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                res_d  = {fa_y, res_q[WIDTH-1:1]};
                op_a_d = op_a_q >> 1;
                op_b_d = op_b_q >> 1;
                cy_d   = fa_carry;
                cnt_d  = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    c_msb_d = cy_q;
                    state_d = StDone;
                end
            end
            StDone: begin
                done_d  = 1'b1;
                cout_d  = cy_q;
                ovf_d   = cy_q ^ c_msb_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            res_q   <= '0;
            cy_q    <= 1'b0;
            c_msb_q <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            res_q   <= res_d;
            cy_q    <= cy_d;
            c_msb_q <= c_msb_d;
            done_q  <= done_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy_o   = (state_q == StShift) || (state_q == StDone);
    assign done_o   = done_q;
    assign result_o = res_q;
    assign cout_o   = cout_q;
    assign ovf_o    = ovf_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed and exhaustive checks of serial_add_sub at WIDTH=8 and WIDTH=4,
// with a queue of expected results compared as each done pulse appears.
module tb_serial_add_sub;

    typedef struct {
        logic [7:0] res;
        logic       cout;
        logic       ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       start8 = 1'b0, sub8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0, res8;
    logic       busy8, done8, cout8, ovf8;

    logic       start4 = 1'b0, sub4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0, res4;
    logic       busy4, done4, cout4, ovf4;

    int checks = 0;
    int errors = 0;
    exp_t q8[$];
    exp_t q4[$];

    serial_add_sub #(.WIDTH(8)) u_dut8 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start8),
        .sub_i    (sub8),
        .a_i      (a8),
        .b_i      (b8),
        .busy_o   (busy8),
        .done_o   (done8),
        .result_o (res8),
        .cout_o   (cout8),
        .ovf_o    (ovf8)
    );

    serial_add_sub #(.WIDTH(4)) u_dut4 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start4),
        .sub_i    (sub4),
        .a_i      (a4),
        .b_i      (b4),
        .busy_o   (busy4),
        .done_o   (done4),
        .result_o (res4),
        .cout_o   (cout4),
        .ovf_o    (ovf4)
    );

    // Reference: modular sum, unsigned carry/no-borrow, and overflow from sign rules.
    function automatic exp_t model(input int unsigned w, input logic [7:0] a,
                                   input logic [7:0] b, input logic sub);
        logic [8:0] mask, sum, bb;
        logic       sa, sb, sr;
        exp_t       e;
        mask   = (9'd1 << w) - 9'd1;
        bb     = sub ? (~{1'b0, b} & mask) : {1'b0, b};
        sum    = {1'b0, a} + bb + {8'd0, sub};
        e.res  = sum[7:0] & mask[7:0];
        e.cout = sum[w];
        sa     = a[w-1];
        sb     = b[w-1];
        sr     = e.res[w-1];
        e.ovf  = sub ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One 8-bit op; latency is the sampling edge (counted from the accept edge)
    // at which done is first seen high.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic sub);
        exp_t e;
        int   n;
        @(negedge clk);
        a8 = a; b8 = b; sub8 = sub; start8 = 1'b1;
        q8.push_back(model(8, a, b, sub));
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        check("busy8", busy8, 1);
        n = 1;
        while (!done8 && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check("done8", done8, 1);
        check("latency8", n, 10);
        e = q8.pop_front();
        check("res8", res8, e.res);
        check("cout8", cout8, e.cout);
        check("ovf8", ovf8, e.ovf);
        @(negedge clk);
        check("done8_pulse", done8, 0);
        check("res8_held", res8, e.res);
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic sub);
        exp_t e;
        int   n;
        @(negedge clk);
        a4 = a; b4 = b; sub4 = sub; start4 = 1'b1;
        q4.push_back(model(4, {4'd0, a}, {4'd0, b}, sub));
        @(posedge clk);
        @(negedge clk);
        start4 = 1'b0;
        n = 0;
        while (!done4 && n < 20) begin
            @(negedge clk);
            n++;
        end
        e = q4.pop_front();
        check("done4", done4, 1);
        check("res4", res4, e.res[3:0]);
        check("cout4", cout4, e.cout);
        check("ovf4", ovf4, e.ovf);
        @(negedge clk);
    endtask

    initial begin
        exp_t e;
        int   pulses;
        logic [7:0] first_res;

        repeat (2) @(negedge clk);
        check("rst_busy8", busy8, 0);
        check("rst_done8", done8, 0);
        check("rst_res8", res8, 0);
        check("rst_cout8", cout8, 0);
        check("rst_ovf8", ovf8, 0);
        check("rst_res4", res4, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run8(8'd100, 8'd27, 1'b0);
        run8(8'hFF, 8'h01, 1'b0);
        run8(8'h7F, 8'h01, 1'b0);
        run8(8'd5, 8'd3, 1'b1);
        run8(8'd3, 8'd5, 1'b1);
        run8(8'h80, 8'h01, 1'b1);
        run8(8'hA5, 8'h5A, 1'b1);

        // Second start two cycles into an op must be ignored.
        @(negedge clk);
        a8 = 8'd10; b8 = 8'd20; sub8 = 1'b0; start8 = 1'b1;
        q8.push_back(model(8, 8'd10, 8'd20, 1'b0));
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        a8 = 8'd99; b8 = 8'd1; sub8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        pulses = 0;
        first_res = 8'hXX;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done8) begin
                if (pulses == 0) first_res = res8;
                pulses++;
            end
        end
        e = q8.pop_front();
        check("ignore_pulses", pulses, 1);
        check("ignore_res", first_res, e.res);
        check("ignore_res_held", res8, e.res);

        // Reset in SHIFT with count=3 aborts the op.
        @(negedge clk);
        a8 = 8'h55; b8 = 8'h0F; sub8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("pre_rst_busy", busy8, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy8, 0);
        check("midrst_done", done8, 0);
        check("midrst_res", res8, 0);
        check("midrst_cout", cout8, 0);
        check("midrst_ovf", ovf8, 0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done8 || busy8) pulses++;
        end
        check("midrst_no_done", pulses, 0);
        run8(8'd200, 8'd100, 1'b0);

        for (int s = 0; s < 2; s++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    run4(4'(a), 4'(b), s[0]);
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
